// File: rtl/llr_loader.sv
// llr_loader: gathers N_V channel LLRs, one per beat, into a packed frame for the decoder.
// Optional macro LLR_SAT_EN: symmetric saturation of each beat instead of truncation.
module llr_loader #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_V      = 44,
  parameter int unsigned IN_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_WIDTH-1:0] in_llr,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*N_V-1:0]       all_llrs,
  output logic                       frame_err
);

  localparam int unsigned CntW = (N_V > 1) ? $clog2(N_V) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(N_V - 1);

  typedef enum logic {StFill, StFull} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [WIDTH*N_V-1:0] llrs_q;
  logic                 accept;
  logic [WIDTH-1:0]     beat;
  logic                 unused_in;

`ifdef LLR_SAT_EN
  localparam logic signed [IN_WIDTH-1:0] SatPos = IN_WIDTH'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SatNeg = -SatPos;

  logic signed [IN_WIDTH-1:0] clamped;

  // Symmetric clamp: the most-negative code never reaches the decoder.
  always_comb begin
    clamped = in_llr;
    if (in_llr > SatPos) begin
      clamped = SatPos;
    end else if (in_llr < SatNeg) begin
      clamped = SatNeg;
    end
  end

  assign beat      = clamped[WIDTH-1:0];
  assign unused_in = ^clamped;
`else
  assign beat      = in_llr[WIDTH-1:0];
  assign unused_in = ^in_llr;
`endif

  // ready_q is only ever high in StFill, so it alone qualifies a transfer.
  assign accept = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            state_d = StFull;
            err_d   = !in_last;
          end else if (in_last) begin
            // Short frame: drop it but leave the written slots as they are.
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFull: begin
        if (out_ready) begin
          state_d = StFill;
        end
      end
    endcase
    ready_d = (state_d == StFill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      llrs_q <= '0;
    end else if (accept) begin
      llrs_q[cnt_q*WIDTH +: WIDTH] <= beat;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q == StFull);
  assign all_llrs  = llrs_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_llr_loader.sv
// Self-checking bench for llr_loader: randomized frames against an arithmetic reference model.
`timescale 1ns/1ps
module tb_llr_loader;
  localparam int W  = 8;
  localparam int NV = 44;
  localparam int IW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [IW-1:0] in_llr = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 frame_err;
  logic [W*NV-1:0]      all_llrs;

  int passed = 0;
  int total  = 0;
  int err_pulses = 0;
  int err_double = 0;
  int busy_accepts = 0;
  logic err_prev = 1'b0;

  int              stim [NV];
  logic [W*NV-1:0] exp_vec;

  always #5 clk = ~clk;

  llr_loader #(.WIDTH(W), .N_V(NV), .IN_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .all_llrs(all_llrs),
    .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (frame_err) err_pulses <= err_pulses + 1;
    if (frame_err && err_prev) err_double <= err_double + 1;
    err_prev <= frame_err;
    if (in_valid && in_ready && out_valid) busy_accepts <= busy_accepts + 1;
  end

  // Reference: what the decoder should see for a channel value v.
  function automatic logic [W-1:0] ref_store(input int v);
    int c;
    c = v;
`ifdef LLR_SAT_EN
    if (c > 127) c = 127;
    if (c < -127) c = -127;
`endif
    return W'(c);
  endfunction

  function automatic void build_exp();
    for (int i = 0; i < NV; i++) exp_vec[i*W +: W] = ref_store(stim[i]);
  endfunction

  function automatic void rand_stim();
    for (int i = 0; i < NV; i++) stim[i] = int'($urandom_range(1023)) - 512;
  endfunction

  task automatic send_beat(input int v, input logic last);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_llr   = IW'(v);
    in_last  = last;
    n = 0;
    forever begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        total++;
        $display("FAIL beat_accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        break;
      end
    end
  endtask

  task automatic send_frame(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_beat(stim[i], i == last_at);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b, required 0", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
    else passed++;
    total++;
    if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %0b, required 0", frame_err);
    else passed++;
    total++;
    if (all_llrs !== '0) $display("FAIL reset_all_llrs: got %h, required 0", all_llrs);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL ready_before_edge: got %0b, required 0", in_ready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_edge: got %0b, required 1", in_ready);
    else passed++;
  endtask

  task automatic test_sequential();
    int bad;
    for (int i = 0; i < NV; i++) stim[i] = i;
    build_exp();
    send_frame(NV, NV - 1, 1'b0);
    total++;
    if (out_valid !== 1'b1) $display("FAIL seq_out_valid: got %0b, required 1", out_valid);
    else passed++;
    total++;
    if (in_ready !== 1'b0) $display("FAIL seq_in_ready: got %0b, required 0", in_ready);
    else passed++;
    total++;
    if (all_llrs !== exp_vec) $display("FAIL seq_frame: got %h, required %h", all_llrs, exp_vec);
    else passed++;
    bad = 0;
    in_valid = 1'b1;
    in_llr   = 10'sd99;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || all_llrs !== exp_vec) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL seq_hold: got %0d unstable cycles, required 0", bad);
    else passed++;
    drain();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL seq_release: got out_valid=%0b in_ready=%0b, required 0/1", out_valid,
               in_ready);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [W-1:0] want [4];
    logic [W-1:0] got;
`ifdef LLR_SAT_EN
    want = '{8'h7F, 8'h81, 8'h81, 8'h7F};
`else
    want = '{8'h2C, 8'hD4, 8'h80, 8'h7F};
`endif
    rand_stim();
    stim[0] = 300;
    stim[1] = -300;
    stim[2] = -128;
    stim[3] = 127;
    build_exp();
    send_frame(NV, NV - 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      got = all_llrs[i*W +: W];
      total++;
      if (got !== want[i]) $display("FAIL sat_slot%0d: got %h, required %h", i, got, want[i]);
      else passed++;
    end
    total++;
    if (all_llrs !== exp_vec) $display("FAIL sat_frame: got %h, required %h", all_llrs, exp_vec);
    else passed++;
    drain();
  endtask

  task automatic test_early_last();
    int e0;
    e0 = err_pulses;
    rand_stim();
    build_exp();
    send_frame(11, 10, 1'b0);
    total++;
    if (frame_err !== 1'b1) $display("FAIL early_err_pulse: got %0b, required 1", frame_err);
    else passed++;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL early_state: got out_valid=%0b in_ready=%0b, required 0/1", out_valid,
               in_ready);
    else passed++;
    total++;
    if (all_llrs[11*W-1:0] !== exp_vec[11*W-1:0])
      $display("FAIL early_slots_kept: got %h, required %h", all_llrs[11*W-1:0],
               exp_vec[11*W-1:0]);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (frame_err !== 1'b0) $display("FAIL early_err_width: got %0b, required 0", frame_err);
    else passed++;
    rand_stim();
    build_exp();
    send_frame(NV - 1, -1, 1'b0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL early_next_premature: got %0b, required 0", out_valid);
    else passed++;
    send_beat(stim[NV-1], 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (out_valid !== 1'b1 || all_llrs !== exp_vec)
      $display("FAIL early_next_frame: got valid=%0b %h, required 1 %h", out_valid, all_llrs,
               exp_vec);
    else passed++;
    drain();
    total++;
    if (err_pulses - e0 != 1) $display("FAIL early_err_count: got %0d, required 1", err_pulses - e0);
    else passed++;
  endtask

  task automatic test_no_last();
    rand_stim();
    build_exp();
    send_frame(NV, -1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || frame_err !== 1'b1)
      $display("FAIL nolast_flags: got out_valid=%0b frame_err=%0b, required 1/1", out_valid,
               frame_err);
    else passed++;
    total++;
    if (all_llrs !== exp_vec) $display("FAIL nolast_frame: got %h, required %h", all_llrs, exp_vec);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (frame_err !== 1'b0) $display("FAIL nolast_err_width: got %0b, required 0", frame_err);
    else passed++;
    drain();
  endtask

  task automatic test_random();
    int e0, bad_frames, hold_bad, wait_c;
    e0 = err_pulses;
    bad_frames = 0;
    hold_bad = 0;
    for (int f = 0; f < 100; f++) begin
      rand_stim();
      build_exp();
      send_frame(NV, NV - 1, 1'b1);
      if (out_valid !== 1'b1 || all_llrs !== exp_vec) begin
        bad_frames++;
        if (bad_frames == 1)
          $display("FAIL rand_frame%0d: got valid=%0b %h, required 1 %h", f, out_valid, all_llrs,
                   exp_vec);
      end
      wait_c = $urandom_range(5);
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_llr   = IW'(int'($urandom_range(1023)));
      for (int c = 0; c < wait_c; c++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || all_llrs !== exp_vec) hold_bad++;
      end
      in_last = 1'b0;
      drain();
    end
    total++;
    if (bad_frames != 0) $display("FAIL rand_frames: got %0d bad frames, required 0", bad_frames);
    else passed++;
    total++;
    if (hold_bad != 0) $display("FAIL rand_hold: got %0d unstable cycles, required 0", hold_bad);
    else passed++;
    total++;
    if (busy_accepts != 0)
      $display("FAIL rand_busy_accept: got %0d beats during out_valid, required 0", busy_accepts);
    else passed++;
    total++;
    if (err_pulses != e0) $display("FAIL rand_no_err: got %0d pulses, required 0", err_pulses - e0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int e0;
    rand_stim();
    send_frame(21, -1, 1'b0);
    e0 = err_pulses;
    rst_n = 1'b0;
    #1;
    total++;
    if (all_llrs !== '0) $display("FAIL midrst_llrs: got %h, required 0", all_llrs);
    else passed++;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL midrst_flags: got ready=%0b valid=%0b err=%0b, required 0/0/0", in_ready,
               out_valid, frame_err);
    else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (err_pulses != e0 || frame_err !== 1'b0)
      $display("FAIL midrst_no_err: got %0d pulses, required 0", err_pulses - e0);
    else passed++;
    rand_stim();
    build_exp();
    send_frame(NV, NV - 1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || all_llrs !== exp_vec)
      $display("FAIL midrst_frame: got valid=%0b %h, required 1 %h", out_valid, all_llrs, exp_vec);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL midrst_consume: got %0b, required 0", out_valid);
    else passed++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_saturation();
    test_early_last();
    test_no_last();
    test_random();
    test_reset_mid();
    @(posedge clk); #1;
    total++;
    if (err_double != 0)
      $display("FAIL err_double: got %0d back-to-back frame_err cycles, required 0", err_double);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
